// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer controller and its DMA fetch engine.
package cnn_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int BLOCK_SIZE = 25;
    localparam int LEN_W      = 5;

    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR_ISSUE,
        DONE
    } dma_state_t;

    // Requests longer than one block are trimmed to a full block.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(BLOCK_SIZE)) begin
            return LEN_W'(BLOCK_SIZE);
        end
        return len;
    endfunction

endpackage

// File: rtl/cnn_dma_rd_pipe.sv
// Tracks in-flight memory reads: a LAT-deep shift register of {valid, word index}
// so returning data lands in the word it was issued for.
module cnn_dma_rd_pipe
    import cnn_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [LEN_W-1:0] i_idx,
    output logic             o_valid,
    output logic [LEN_W-1:0] o_idx
);

    logic [LAT-1:0]   r_vld;
    logic [LEN_W-1:0] r_idx [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_idx[0] <= i_idx;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_vld[LAT-1];
    assign o_idx   = r_idx[LAT-1];

endmodule

// File: rtl/cnn_dma_fetch.sv
// Block-transfer engine between the CNN layer controller and the single-port data memory.
//   state    | meaning
//   IDLE     | waiting for start; request fields latched on accept
//   RD_ISSUE | one read strobe per cycle, address base+idx
//   RD_DRAIN | all reads issued; waiting for the last data to return
//   WR_ISSUE | one write strobe per cycle with latched word idx
//   DONE     | one-cycle done pulse, then back to IDLE
module cnn_dma_fetch
    import cnn_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         wr_mode,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [LEN_W-1:0]             length,
    input  logic [BLOCK_SIZE*DATA_W-1:0] wr_data_flat,
    output logic                         busy,
    output logic                         done,
    output logic [BLOCK_SIZE*DATA_W-1:0] rd_data_flat,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int CNT_W = 3;

    dma_state_t       r_state;
    dma_state_t       w_next;
    logic             w_accept;
    logic             w_last;
    logic [LEN_W-1:0] w_len_in;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_outst;
    word_t             r_wr_word [BLOCK_SIZE];
    word_t             r_rd_word [BLOCK_SIZE];

    logic              w_pipe_vld;
    logic [LEN_W-1:0]  w_pipe_idx;

    assign w_len_in = clamp_len(length);
    assign w_last   = (r_idx == r_len - LEN_W'(1));
    assign w_addr   = r_base + ADDR_W'(r_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_len_in == '0) begin
                        w_next = DONE;
                    end else if (wr_mode) begin
                        w_next = WR_ISSUE;
                    end else begin
                        w_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = w_addr;
                if (w_last) begin
                    w_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                busy = 1'b1;
                // The read returning this cycle is captured on the same edge we leave.
                if (r_outst == '0 || (r_outst == CNT_W'(1) && w_pipe_vld)) begin
                    w_next = DONE;
                end
            end
            WR_ISSUE: begin
                busy     = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = w_addr;
                if (r_idx < LEN_W'(BLOCK_SIZE)) begin
                    mem_wdata = r_wr_word[r_idx];
                end
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_outst <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_wr_word[i] <= '0;
                r_rd_word[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_base <= base_addr;
                r_len  <= w_len_in;
                r_idx  <= '0;
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    r_wr_word[i] <= wr_data_flat[i*DATA_W +: DATA_W];
                end
                if (!wr_mode) begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        r_rd_word[i] <= '0;
                    end
                end
            end else if (mem_rd || mem_wr) begin
                r_idx <= r_idx + LEN_W'(1);
            end

            r_outst <= r_outst + CNT_W'(mem_rd) - CNT_W'(w_pipe_vld);

            if (w_pipe_vld && w_pipe_idx < LEN_W'(BLOCK_SIZE)) begin
                r_rd_word[w_pipe_idx] <= word_t'(mem_rdata);
            end
        end
    end

    cnn_dma_rd_pipe #(
        .LAT (MEM_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (mem_rd),
        .i_idx   (r_idx),
        .o_valid (w_pipe_vld),
        .o_idx   (w_pipe_idx)
    );

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_flat
        assign rd_data_flat[g*DATA_W +: DATA_W] = r_rd_word[g];
    end

endmodule

// File: tb/tb_cnn_dma_fetch.sv
// Bench for cnn_dma_fetch: two instances (read latency 1 and 3) driven in lockstep,
// each against its own memory, checked every cycle against a transaction-level model.
module tb_cnn_dma_fetch;
    import cnn_pkg::*;

    localparam int FW = BLOCK_SIZE * DATA_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          wr_mode = 1'b0;
    logic [15:0]   base_addr = '0;
    logic [4:0]    length = '0;
    logic [FW-1:0] wr_data_flat = '0;

    logic          o_busy [2];
    logic          o_done [2];
    logic [FW-1:0] o_rd_flat [2];
    logic [15:0]   o_mem_addr [2];
    logic          o_mem_rd [2];
    logic          o_mem_wr [2];
    logic [15:0]   o_mem_wdata [2];
    logic [15:0]   mem_rdata [2];

    always #5 clk = ~clk;

    cnn_dma_fetch #(.MEM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode),
        .base_addr(base_addr), .length(length), .wr_data_flat(wr_data_flat),
        .busy(o_busy[0]), .done(o_done[0]), .rd_data_flat(o_rd_flat[0]),
        .mem_addr(o_mem_addr[0]), .mem_rd(o_mem_rd[0]), .mem_wr(o_mem_wr[0]),
        .mem_wdata(o_mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    cnn_dma_fetch #(.MEM_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode),
        .base_addr(base_addr), .length(length), .wr_data_flat(wr_data_flat),
        .busy(o_busy[1]), .done(o_done[1]), .rd_data_flat(o_rd_flat[1]),
        .mem_addr(o_mem_addr[1]), .mem_rd(o_mem_rd[1]), .mem_wr(o_mem_wr[1]),
        .mem_wdata(o_mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [15:0] hash16(input int a);
        return 16'(a * 40503 + 12345) ^ 16'(a >>> 3);
    endfunction

    // Memories: one per instance; unread cycles return noise so stray captures show up.
    logic [15:0] mem0 [65536];
    logic [15:0] mem1 [65536];
    logic [15:0] rq0;
    logic [15:0] rq1 [3];
    logic        mem_init = 1'b0;
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) begin
                mem0[i] <= hash16(i);
                mem1[i] <= hash16(i);
            end
        end
        if (pl_we) begin
            mem0[pl_addr] <= pl_data;
            mem1[pl_addr] <= pl_data;
        end
        if (o_mem_wr[0]) mem0[o_mem_addr[0]] <= o_mem_wdata[0];
        if (o_mem_wr[1]) mem1[o_mem_addr[1]] <= o_mem_wdata[1];
        rq0    <= o_mem_rd[0] ? mem0[o_mem_addr[0]] : 16'($urandom);
        rq1[0] <= o_mem_rd[1] ? mem1[o_mem_addr[1]] : 16'($urandom);
        rq1[1] <= rq1[0];
        rq1[2] <= rq1[1];
    end

    assign mem_rdata[0] = rq0;
    assign mem_rdata[1] = rq1[2];

    // Transaction-level model state
    logic [15:0]   gold [65536];
    logic [FW-1:0] exp_rd = '0;
    logic          tx_on = 1'b0;
    int            cyc = 0;
    logic          cur_wr = 1'b0;
    logic [15:0]   cur_base = '0;
    int            cur_l = 0;
    int            cur_rst = 0;
    logic [FW-1:0] cur_data = '0;
    int            done_cyc [2];
    logic [15:0]   obs_addr [2][32];
    logic          chk_en = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int d, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d cyc=%0d t=%0t: got %0h expected %0h", nm, d, cyc, $time, got, exp);
        end
    endtask

    task automatic check_dut(input int d);
        int   lat;
        int   dd;
        logic in_tx;
        logic ab;
        logic stb;
        lat   = (d == 0) ? 1 : 3;
        dd    = (cur_l == 0) ? 1 : (cur_wr ? cur_l + 1 : cur_l + lat + 1);
        in_tx = tx_on && cyc >= 1;
        ab    = in_tx && cur_rst != 0 && cyc > cur_rst;
        stb   = in_tx && !ab && cyc <= cur_l;
        chk("mem_rd", d, FW'(o_mem_rd[d]), FW'(stb && !cur_wr));
        chk("mem_wr", d, FW'(o_mem_wr[d]), FW'(stb && cur_wr));
        if (stb) begin
            chk("mem_addr", d, FW'(o_mem_addr[d]), FW'(16'(cur_base + 16'(cyc - 1))));
            if (cur_wr) begin
                chk("mem_wdata", d, FW'(o_mem_wdata[d]), FW'(cur_data[(cyc-1)*16 +: 16]));
            end
            if (cyc < 32) obs_addr[d][cyc] = o_mem_addr[d];
        end
        chk("busy", d, FW'(o_busy[d]), FW'(in_tx && !ab && cyc < dd));
        chk("done", d, FW'(o_done[d]), FW'(in_tx && !ab && cyc == dd));
        if (o_done[d] && in_tx) done_cyc[d] = cyc;
        if (!in_tx || ab || cur_wr || cyc >= dd) begin
            chk("rd_data_flat", d, o_rd_flat[d], exp_rd);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) check_dut(d);
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        gold[a] = v;
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic run_tx(input logic wr, input logic [15:0] base, input logic [4:0] len,
                          input logic [FW-1:0] data, input int rst_cyc, input bit junk);
        int l;
        int d0;
        int d1;
        int mx;
        l  = (len > 25) ? 25 : int'(len);
        d0 = (l == 0) ? 1 : (wr ? l + 1 : l + 2);
        d1 = (l == 0) ? 1 : (wr ? l + 1 : l + 4);
        mx = (rst_cyc != 0) ? rst_cyc + 2 : d1;
        start = 1'b1; wr_mode = wr; base_addr = base; length = len; wr_data_flat = data;
        @(posedge clk);
        tx_on = 1'b1; cyc = 0; cur_wr = wr; cur_base = base; cur_l = l;
        cur_rst = rst_cyc; cur_data = data;
        done_cyc[0] = -1; done_cyc[1] = -1;
        if (wr) begin
            for (int i = 0; i < l; i++) gold[16'(base + 16'(i))] = data[i*16 +: 16];
        end else begin
            exp_rd = '0;
            if (rst_cyc == 0) begin
                for (int i = 0; i < l; i++) exp_rd[i*16 +: 16] = gold[16'(base + 16'(i))];
            end
        end
        #1; cyc = 1;
        while (cyc <= mx) begin
            start = junk && cyc <= d0 && ($urandom_range(0, 1) == 1);
            if (start) begin
                wr_mode = 1'($urandom); base_addr = 16'($urandom); length = 5'($urandom);
            end
            reset = (rst_cyc != 0 && cyc == rst_cyc);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; reset = 1'b0;
        tx_on = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [FW-1:0] rand_data();
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) v[i*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    initial begin
        logic [FW-1:0] dat;
        logic [15:0]   last_wbase;
        logic [15:0]   b;
        logic          w;
        done_cyc[0] = -1; done_cyc[1] = -1;
        for (int i = 0; i < 65536; i++) gold[i] = hash16(i);
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        chk_en = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst_busy", 0, FW'(o_busy[0]), FW'(0));
        chk("rst_mem_addr", 1, FW'(o_mem_addr[1]), FW'(0));
        chk("rst_rd_flat", 0, o_rd_flat[0], FW'(0));

        // Small read with hand-known data
        preload(16'h0010, 16'd5);
        preload(16'h0011, 16'hFFFE);
        preload(16'h0012, 16'd7);
        run_tx(1'b0, 16'h0010, 5'd3, '0, 0, 0);
        chk("rd3_done_cyc_lat1", 0, FW'(done_cyc[0]), FW'(5));
        chk("rd3_done_cyc_lat3", 1, FW'(done_cyc[1]), FW'(7));
        chk("rd3_word0", 0, FW'(o_rd_flat[0][15:0]), FW'(16'h0005));
        chk("rd3_word1", 0, FW'(o_rd_flat[0][31:16]), FW'(16'hFFFE));
        chk("rd3_word2", 1, FW'(o_rd_flat[1][47:32]), FW'(16'h0007));
        chk("rd3_upper_zero", 0, FW'(o_rd_flat[0][FW-1:48]), FW'(0));

        // Full-block write then readback
        dat = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) dat[i*16 +: 16] = 16'(i + 1);
        run_tx(1'b1, 16'h0100, 5'd25, dat, 0, 0);
        chk("wr25_done_cyc", 0, FW'(done_cyc[0]), FW'(26));
        chk("wr25_first_addr", 0, FW'(obs_addr[0][1]), FW'(16'h0100));
        chk("wr25_last_addr", 1, FW'(obs_addr[1][25]), FW'(16'h0118));
        run_tx(1'b0, 16'h0100, 5'd25, '0, 0, 1);
        chk("rb25_word0", 0, FW'(o_rd_flat[0][15:0]), FW'(1));
        chk("rb25_word24", 1, FW'(o_rd_flat[1][399:384]), FW'(25));
        chk("rb25_done_cyc_lat3", 1, FW'(done_cyc[1]), FW'(29));

        // Address wrap
        run_tx(1'b0, 16'hFFFF, 5'd2, '0, 0, 0);
        chk("wrap_addr0", 0, FW'(obs_addr[0][1]), FW'(16'hFFFF));
        chk("wrap_addr1", 0, FW'(obs_addr[0][2]), FW'(16'h0000));
        chk("wrap_done_cyc", 0, FW'(done_cyc[0]), FW'(4));

        // Zero length and clamped length
        run_tx(1'b0, 16'h0020, 5'd0, '0, 0, 1);
        chk("len0_done_cyc", 1, FW'(done_cyc[1]), FW'(1));
        chk("len0_rd_clear", 0, o_rd_flat[0], FW'(0));
        run_tx(1'b1, 16'h0030, 5'd0, rand_data(), 0, 0);
        chk("len0w_done_cyc", 0, FW'(done_cyc[0]), FW'(1));
        run_tx(1'b0, 16'($urandom), 5'd31, '0, 0, 0);
        chk("len31_done_cyc", 0, FW'(done_cyc[0]), FW'(27));

        // Junk start while busy, then back-to-back start right after done
        run_tx(1'b0, 16'h0040, 5'd4, '0, 0, 1);
        chk("lat3_done_cyc", 1, FW'(done_cyc[1]), FW'(8));
        run_tx(1'b1, 16'h0050, 5'd3, rand_data(), 0, 1);
        chk("b2b_done_cyc", 1, FW'(done_cyc[1]), FW'(4));

        // Randomised traffic
        last_wbase = 16'h0050;
        for (int t = 0; t < 60; t++) begin
            w = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'hFFF0 + 16'($urandom_range(0, 15));
                1: b = last_wbase + 16'($urandom_range(0, 8));
                default: b = 16'($urandom);
            endcase
            if (w) last_wbase = b;
            run_tx(w, b, 5'($urandom_range(0, 31)), rand_data(), 0, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Reset in the middle of a read
        run_tx(1'b0, 16'h0100, 5'd25, '0, 0, 0);
        run_tx(1'b0, 16'h0200, 5'd10, '0, 2, 0);
        chk("abort_rd_zero0", 0, o_rd_flat[0], FW'(0));
        chk("abort_rd_zero1", 1, o_rd_flat[1], FW'(0));
        chk("abort_no_done", 0, FW'(done_cyc[0] == -1 && done_cyc[1] == -1), FW'(1));
        run_tx(1'b0, last_wbase, 5'd25, '0, 0, 1);
        run_tx(1'b0, 16'h0100, 5'd25, '0, 0, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
